// File: rtl/scan_select_sequencer.sv
// rtl/scan_select_sequencer.sv - slot scan sequencer driving a 2-to-4 decoder
//
// Purpose:
//   Steps the decoder select {o_a,o_b} through slots 0..3. Each active slot
//   holds o_enable high for DWELL_CYCLES clocks. Masked slots are skipped.
//   A one-cycle i_start runs one non-wrapping sweep. A high i_run level scans
//   continuously, wrapping 3->0, until run is low at a slot boundary.
//
// Ports:
//   i_clk         in   system clock, rising edge
//   i_rst         in   synchronous reset, active-high, highest priority
//   i_start       in   single-sweep request, honoured only when idle
//   i_run         in   continuous-scan level; wins over i_start
//   i_skip_mask   in   [3:0] bit i set = slot i skipped; read at slot boundaries
//   o_a, o_b      out  slot index MSB/LSB; hold their value after termination
//   o_enable      out  decoder enable during an active slot's dwell
//   o_slot_start  out  pulse on the first dwell cycle of each slot
//   o_busy        out  high while a sweep or scan is in progress
//   o_done        out  pulse when a sweep or scan terminates
//
// Configuration macro:
//   SCAN_BLANKING_EN - inserts one BLANK cycle (enable low, busy high, old slot
//   held) between consecutive slots. It is never inserted after the last slot.

module scan_select_sequencer #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_run,
  input  logic [3:0] i_skip_mask,
  output logic       o_a,
  output logic       o_b,
  output logic       o_enable,
  output logic       o_slot_start,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CNT_W = $clog2(DWELL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

`ifdef SCAN_BLANKING_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DWELL = 2'd1, S_BLANK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DWELL = 2'd1} state_t;
`endif

  state_t           r_state, w_state;
  logic [1:0]       r_slot, w_slot;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_cont, w_cont;
  logic             r_done_evt, w_done_evt;
  logic [2:0]       w_first, w_succ;
`ifdef SCAN_BLANKING_EN
  logic [1:0]       r_next, w_next;
`endif

  // Lowest unmasked slot as {found, slot}.
  function automatic logic [2:0] f_first(input logic [3:0] mask);
    logic [2:0] res;
    res = 3'b000;
    for (int s = 3; s >= 0; s--) begin
      if (!mask[2'(s)]) res = {1'b1, 2'(s)};
    end
    return res;
  endfunction

  // Nearest unmasked slot above cur as {found, slot}. With wrap, the search
  // continues through 0 and ends on cur itself (distance 4).
  function automatic logic [2:0] f_next(input logic [1:0] cur, input logic [3:0] mask,
                                        input logic wrap);
    logic [2:0] res;
    logic [2:0] sum;
    res = {1'b0, cur};
    for (int d = 4; d >= 1; d--) begin
      sum = {1'b0, cur} + 3'(d);
      if (!mask[sum[1:0]] && (wrap || !sum[2])) res = {1'b1, sum[1:0]};
    end
    return res;
  endfunction

  assign w_first = f_first(i_skip_mask);
  assign w_succ  = f_next(r_slot, i_skip_mask, r_cont);

  always_comb begin
    w_state    = r_state;
    w_slot     = r_slot;
    w_cnt      = r_cnt;
    w_cont     = r_cont;
    w_done_evt = 1'b0;
`ifdef SCAN_BLANKING_EN
    w_next     = r_next;
`endif
    case (r_state)
      S_IDLE: begin
        // The cycle carrying a pending done still counts as busy, so requests
        // seen then are dropped; this also paces empty-mask runs to every
        // other cycle.
        if (!r_done_evt && (i_start || i_run)) begin
          w_cont = i_run;
          if (w_first[2]) begin
            w_state = S_DWELL;
            w_slot  = w_first[1:0];
            w_cnt   = '0;
          end else begin
            w_done_evt = 1'b1;
          end
        end
      end
      S_DWELL: begin
        if (r_cnt == CNT_LAST) begin
          if (w_succ[2] && (!r_cont || i_run)) begin
`ifdef SCAN_BLANKING_EN
            w_state = S_BLANK;
            w_next  = w_succ[1:0];
`else
            w_slot  = w_succ[1:0];
            w_cnt   = '0;
`endif
          end else begin
            w_state    = S_IDLE;
            w_done_evt = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
`ifdef SCAN_BLANKING_EN
      S_BLANK: begin
        w_state = S_DWELL;
        w_slot  = r_next;
        w_cnt   = '0;
      end
`endif
      default: w_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the state of the previous cycle, which puts
  // the first enable one edge after the request is sampled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_slot       <= 2'b00;
      r_cnt        <= '0;
      r_cont       <= 1'b0;
      r_done_evt   <= 1'b0;
      o_a          <= 1'b0;
      o_b          <= 1'b0;
      o_enable     <= 1'b0;
      o_slot_start <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_slot       <= w_slot;
      r_cnt        <= w_cnt;
      r_cont       <= w_cont;
      r_done_evt   <= w_done_evt;
      o_a          <= r_slot[1];
      o_b          <= r_slot[0];
      o_enable     <= (r_state == S_DWELL);
      o_slot_start <= (r_state == S_DWELL) && (r_cnt == '0);
      o_busy       <= (r_state != S_IDLE);
      o_done       <= r_done_evt;
    end
  end

`ifdef SCAN_BLANKING_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) r_next <= 2'b00;
    else       r_next <= w_next;
  end
`endif

endmodule
